mem_controller: RTL

//  Memory-side end of the byte-lane access path: consumes the lane select (datSel) produced by

---
 rtl/mem_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_controller.sv
// Multi-cycle byte-lane memory controller: one RAM access per request, with lane alignment and fault on ACC_BAD.
// Optional feature: define SIGN_EXT_EN to sign-extend LB/HB reads (default zero-extends).
module mem_controller #(
    parameter int WORD        = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [1:0]      datSel_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wdat_i,
    output logic            ack_o,
    output logic            fault_o,
    output logic [WORD-1:0] rdat_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [1:0]      mem_be_o,
    output logic [WORD-2:0] mem_addr_o,
    output logic [WORD-1:0] mem_wdat_o,
    input  logic [WORD-1:0] mem_rdat_i
);
    localparam int H = WORD / 2;
    localparam logic [1:0] ACC_LB   = 2'd1;
    localparam logic [1:0] ACC_HB   = 2'd2;
    localparam logic [1:0] ACC_WORD = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE, S_FAULT} state_t;

    state_t          state_q;
    logic [1:0]      sel_q;
    logic [3:0]      cnt_q;
    logic [1:0]      be_d;
    logic [WORD-1:0] wdat_d;
    logic [WORD-1:0] rdat_d;
    logic [H-1:0]    byte_sel;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = addr_i[0];

    always_comb begin
        case (datSel_i)
            ACC_LB:   be_d = 2'b01;
            ACC_HB:   be_d = 2'b10;
            ACC_WORD: be_d = 2'b11;
            default:  be_d = 2'b00;
        endcase
        // Byte writes replicate the low byte so either lane can take it.
        wdat_d   = (datSel_i == ACC_WORD) ? wdat_i : {2{wdat_i[H-1:0]}};
        byte_sel = (sel_q == ACC_HB) ? mem_rdat_i[WORD-1:H] : mem_rdat_i[H-1:0];
`ifdef SIGN_EXT_EN
        rdat_d = {{H{byte_sel[H-1]}}, byte_sel};
`else
        rdat_d = {{H{1'b0}}, byte_sel};
`endif
        if (sel_q == ACC_WORD) rdat_d = mem_rdat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sel_q      <= 2'd0;
            cnt_q      <= 4'd0;
            ack_o      <= 1'b0;
            fault_o    <= 1'b0;
            rdat_o     <= '0;
            mem_en_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 2'b00;
            mem_addr_o <= '0;
            mem_wdat_o <= '0;
        end else begin
            ack_o    <= 1'b0;
            fault_o  <= 1'b0;
            mem_en_o <= 1'b0;
            case (state_q)
                S_IDLE: if (req_i) begin
                    if (datSel_i == 2'd0) begin
                        state_q <= S_FAULT;
                        ack_o   <= 1'b1;
                        fault_o <= 1'b1;
                    end else begin
                        state_q    <= S_ACCESS;
                        sel_q      <= datSel_i;
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= we_i;
                        mem_be_o   <= be_d;
                        mem_addr_o <= addr_i[WORD-1:1];
                        mem_wdat_o <= wdat_d;
                    end
                end
                S_ACCESS: begin
                    cnt_q <= 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_DONE;
                        ack_o   <= 1'b1;
                        if (!mem_we_o) rdat_o <= rdat_d;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_DONE;
                        ack_o   <= 1'b1;
                        if (!mem_we_o) rdat_o <= rdat_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
